pll_reconfig_seq: RTL and testbench

- Avalon-MM master that drives the management port of the Cyclone V PLL reconfiguration core.
- That core in turn drives the PLL's 64-bit reconfig_to_pll bus and consumes reconfig_from_pll.
- On request, it loads one of two stored clock profiles: 0 = NTSC master-clock set, 1 = PAL set. It writes the profile's N, M, fractional K and C0..C3 counter values, issues start, then waits for stable lock.
- It holds PLL-clocked logic in reset for the whole sequence and reports completion or timeout.

---
 rtl/pll_reconfig_pkg.sv | 24 ++
 rtl/pll_reconfig_table.sv | 26 ++
 rtl/pll_reconfig_seq.sv | 134 +++++++++++++
 tb/tb_pll_reconfig_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reconfig_pkg.sv
// pll_reconfig_pkg: reconfig register map, stored clock profiles and sequencer states
package pll_reconfig_pkg;
  localparam logic [5:0] ADDR_MODE  = 6'h00;
  localparam logic [5:0] ADDR_START = 6'h02;
  localparam logic [5:0] ADDR_N     = 6'h03;
  localparam logic [5:0] ADDR_M     = 6'h04;
  localparam logic [5:0] ADDR_C     = 6'h05;
  localparam logic [5:0] ADDR_K     = 6'h07;
  localparam int unsigned NUM_WRITES = 9;
  typedef struct packed {
    logic [31:0]      n;
    logic [31:0]      m;
    logic [31:0]      k;
    logic [0:3][31:0] c;
  } profile_t;
  // C words carry their counter index in [22:18]
  localparam profile_t PROFILE_NTSC = '{
    n: 32'h00010000, m: 32'h00000404, k: 32'h1962D376,
    c: {32'h00020403, 32'h00040E0E, 32'h00083838, 32'h000C3838}};
  localparam profile_t PROFILE_PAL = '{
    n: 32'h00010000, m: 32'h00000505, k: 32'h2B7E1516,
    c: {32'h00020504, 32'h00041111, 32'h00084444, 32'h000C4444}};
  typedef enum logic [1:0] {IDLE, WR, LOCK} state_t;
endpackage

// File: rtl/pll_reconfig_table.sv
// pll_reconfig_table: maps (profile, step) to the reconfig register write for that step
module pll_reconfig_table
  import pll_reconfig_pkg::*;
(
  input  logic        profile_i,
  input  logic [3:0]  step_i,
  output logic [5:0]  addr_o,
  output logic [31:0] data_o,
  output logic        last_o
);
  profile_t p;
  always_comb begin
    p = profile_i ? PROFILE_PAL : PROFILE_NTSC;
    addr_o = ADDR_MODE;
    data_o = '0;
    case (step_i)
      4'd1: begin addr_o = ADDR_N; data_o = p.n; end
      4'd2: begin addr_o = ADDR_M; data_o = p.m; end
      4'd3: begin addr_o = ADDR_K; data_o = p.k; end
      4'd4, 4'd5, 4'd6, 4'd7: begin addr_o = ADDR_C; data_o = p.c[step_i[1:0]]; end
      4'd8: begin addr_o = ADDR_START; data_o = 32'd1; end
      default: ;
    endcase
  end
  assign last_o = step_i == 4'(NUM_WRITES - 1);
endmodule

// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq: Avalon-MM master loading a stored profile into the PLL reconfig core,
// holding PLL-domain logic in reset until lock is qualified or the lock timer expires
module pll_reconfig_seq
  import pll_reconfig_pkg::*;
#(
  parameter int unsigned LOCK_TIMEOUT = 1048576,
  parameter int unsigned LOCK_STABLE  = 16
) (
  input  logic        clk_74a,
  input  logic        reset_n,
  input  logic        req,
  input  logic        profile_sel,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        active_profile,
  output logic        pll_hold,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        mgmt_write,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked
);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  state_t        state_q, state_d;
  logic [3:0]    step_q, step_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [1:0]    sync_q;
  logic          wr_q, wr_d, prof_q, prof_d, done_q, done_d;
  logic          error_q, error_d, active_q, active_d, hold_q, hold_d;
  logic          lk, accepted, qualified, tbl_last;
  logic [5:0]    tbl_addr;
  logic [31:0]   tbl_data;

  pll_reconfig_table u_table (
    .profile_i(prof_q),
    .step_i   (step_q),
    .addr_o   (tbl_addr),
    .data_o   (tbl_data),
    .last_o   (tbl_last)
  );

  assign lk             = sync_q[1];
  assign accepted       = wr_q && !mgmt_waitrequest;
  assign busy           = state_q != IDLE;
  assign done           = done_q;
  assign error          = error_q;
  assign active_profile = active_q;
  assign pll_hold       = hold_q;
  assign mgmt_write     = wr_q;
  assign mgmt_address   = state_q == WR ? tbl_addr : '0;
  assign mgmt_writedata = state_q == WR ? tbl_data : '0;

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    wr_d      = wr_q;
    prof_d    = prof_q;
    done_d    = 1'b0;
    error_d   = error_q;
    active_d  = active_q;
    hold_d    = hold_q;
    timer_d   = timer_q + 1'b1;
    stable_d  = !lk ? '0 : stable_q == SW'(LOCK_STABLE) ? stable_q : stable_q + 1'b1;
    qualified = stable_d == SW'(LOCK_STABLE);
    case (state_q)
      IDLE: begin
        // power-up release only; after a timeout the hold stays until a later success
        if (qualified && !error_q) hold_d = 1'b0;
        if (req) begin
          state_d = WR;
          prof_d  = profile_sel;
          error_d = 1'b0;
          hold_d  = 1'b1;
          step_d  = '0;
          wr_d    = 1'b1;
        end
      end
      WR: begin
        if (accepted) begin
          wr_d   = 1'b0;
          step_d = step_q + 1'b1;
          if (tbl_last) begin
            state_d  = LOCK;
            step_d   = '0;
            timer_d  = '0;
            stable_d = '0;
          end
        end else wr_d = 1'b1;
      end
      LOCK: begin
        if (qualified) begin
          done_d   = 1'b1;
          active_d = prof_q;
          hold_d   = 1'b0;
          state_d  = IDLE;
        end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_74a or negedge reset_n)
    if (!reset_n) begin
      state_q  <= IDLE;
      step_q   <= '0;
      timer_q  <= '0;
      stable_q <= '0;
      sync_q   <= '0;
      wr_q     <= 1'b0;
      prof_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      active_q <= 1'b0;
      hold_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      timer_q  <= timer_d;
      stable_q <= stable_d;
      sync_q   <= {sync_q[0], pll_locked};
      wr_q     <= wr_d;
      prof_q   <= prof_d;
      done_q   <= done_d;
      error_q  <= error_d;
      active_q <= active_d;
      hold_q   <= hold_d;
    end
endmodule

// File: tb/tb_pll_reconfig_seq.sv
// tb_pll_reconfig_seq: directed scenarios for the PLL reconfig sequencer
module tb_pll_reconfig_seq;
  logic clk_74a = 0, reset_n = 1, req = 0, profile_sel = 0, mgmt_waitrequest = 0, pll_locked = 0;
  logic busy, done, error, active_profile, pll_hold, mgmt_write;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  int total = 0, bad = 0, wcnt = 0, gap_bad = 0;
  logic prev_acc = 0;
  logic [5:0]  log_a [256];
  logic [31:0] log_d [256];
  logic [5:0]  exp_a  [9] = '{6'h00, 6'h03, 6'h04, 6'h07, 6'h05, 6'h05, 6'h05, 6'h05, 6'h02};
  logic [31:0] ntsc_d [9] = '{32'h0, 32'h00010000, 32'h00000404, 32'h1962D376, 32'h00020403,
                              32'h00040E0E, 32'h00083838, 32'h000C3838, 32'h1};
  logic [31:0] pal_d  [9] = '{32'h0, 32'h00010000, 32'h00000505, 32'h2B7E1516, 32'h00020504,
                              32'h00041111, 32'h00084444, 32'h000C4444, 32'h1};

  pll_reconfig_seq #(.LOCK_TIMEOUT(400), .LOCK_STABLE(16)) dut (
    .clk_74a(clk_74a), .reset_n(reset_n), .req(req), .profile_sel(profile_sel),
    .busy(busy), .done(done), .error(error), .active_profile(active_profile),
    .pll_hold(pll_hold), .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata),
    .mgmt_write(mgmt_write), .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked)
  );

  always #5 clk_74a = ~clk_74a;

  // log every completed write and any write asserted right after a completion
  always @(posedge clk_74a) begin
    if (prev_acc && mgmt_write) gap_bad = gap_bad + 1;
    prev_acc = mgmt_write && !mgmt_waitrequest;
    if (mgmt_write && !mgmt_waitrequest) begin
      log_a[8'(wcnt)] = mgmt_address;
      log_d[8'(wcnt)] = mgmt_writedata;
      wcnt = wcnt + 1;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk_74a); #1; end
  endtask

  task automatic pulse_req(input logic p);
    profile_sel = p; req = 1; tick(); req = 0;
  endtask

  task automatic wait_writes(input int target, input string name);
    int n = 0;
    while (wcnt < target && n < 300) begin tick(); n++; end
    total++;
    if (wcnt < target) begin bad++; $display("FAIL %s_writes got=%0d exp>=%0d", name, wcnt, target); end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 300) begin tick(); n++; end
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL %s_done got=%b exp=1", name, done); end
  endtask

  task automatic test_reset;
    #2 reset_n = 0;
    tick(3);
    total++;
    if ({busy, done, error, active_profile, pll_hold, mgmt_write} !== 6'b000010) begin
      bad++; $display("FAIL reset_flags got=%b exp=000010", {busy, done, error, active_profile, pll_hold, mgmt_write});
    end
    total++;
    if (mgmt_address !== 6'h0 || mgmt_writedata !== 32'h0) begin
      bad++; $display("FAIL reset_bus got=%h/%h exp=00/00000000", mgmt_address, mgmt_writedata);
    end
  endtask

  task automatic test_powerup;
    int b = 0;
    reset_n = 1;
    for (int i = 0; i < 100; i++) begin tick(); if (busy !== 0 || pll_hold !== 1) b++; end
    pll_locked = 1;
    for (int i = 0; i < 17; i++) begin tick(); if (busy !== 0 || pll_hold !== 1) b++; end
    total++;
    if (b != 0) begin bad++; $display("FAIL powerup_hold_early got=%0d bad cycles exp=0", b); end
    tick();
    total++;
    if (pll_hold !== 0 || busy !== 0) begin bad++; $display("FAIL powerup_release got=hold%b busy%b exp=hold0 busy0", pll_hold, busy); end
  endtask

  task automatic test_ntsc;
    int base = wcnt, g0 = gap_bad, b = 0;
    pll_locked = 0;
    pulse_req(0);
    total++;
    if (busy !== 1 || pll_hold !== 1 || mgmt_write !== 1) begin
      bad++; $display("FAIL ntsc_accept got=busy%b hold%b wr%b exp=111", busy, pll_hold, mgmt_write);
    end
    wait_writes(base + 9, "ntsc");
    pll_locked = 1;
    wait_done("ntsc");
    tick();
    total++;
    if (done !== 0) begin bad++; $display("FAIL ntsc_done_width got=%b exp=0", done); end
    total++;
    if (wcnt - base != 9) begin bad++; $display("FAIL ntsc_count got=%0d exp=9", wcnt - base); end
    for (int i = 0; i < 9; i++) if (log_a[8'(base + i)] !== exp_a[i] || log_d[8'(base + i)] !== ntsc_d[i]) b++;
    total++;
    if (b != 0) begin bad++; $display("FAIL ntsc_table got=%0d wrong entries exp=0", b); end
    total++;
    if (log_a[8'(base + 3)] !== 6'h07 || log_d[8'(base + 3)] !== 32'h1962D376) begin
      bad++; $display("FAIL ntsc_k got=%h/%h exp=07/1962d376", log_a[8'(base + 3)], log_d[8'(base + 3)]);
    end
    total++;
    if (gap_bad != g0) begin bad++; $display("FAIL ntsc_gap got=%0d exp=%0d", gap_bad, g0); end
    total++;
    if (active_profile !== 0 || busy !== 0 || pll_hold !== 0) begin
      bad++; $display("FAIL ntsc_final got=act%b busy%b hold%b exp=000", active_profile, busy, pll_hold);
    end
  endtask

  task automatic test_pal_stall;
    int base = wcnt, b = 0, hb = 0, n;
    logic [5:0] a0;
    logic [31:0] d0;
    pll_locked = 0;
    mgmt_waitrequest = 1;
    pulse_req(1);
    for (int w = 0; w < 9; w++) begin
      n = 0;
      while (mgmt_write !== 1 && n < 20) begin tick(); n++; end
      a0 = mgmt_address; d0 = mgmt_writedata;
      if (a0 !== exp_a[w] || d0 !== pal_d[w]) b++;
      repeat (5) begin tick(); if (mgmt_write !== 1 || mgmt_address !== a0 || mgmt_writedata !== d0) hb++; end
      mgmt_waitrequest = 0; tick(); mgmt_waitrequest = 1;
    end
    total++;
    if (b != 0) begin bad++; $display("FAIL pal_table got=%0d wrong entries exp=0", b); end
    total++;
    if (hb != 0) begin bad++; $display("FAIL pal_stall_hold got=%0d unstable cycles exp=0", hb); end
    pll_locked = 1;
    wait_done("pal");
    mgmt_waitrequest = 0;
    total++;
    if (wcnt - base != 9) begin bad++; $display("FAIL pal_count got=%0d exp=9", wcnt - base); end
    total++;
    if (active_profile !== 1) begin bad++; $display("FAIL pal_active got=%b exp=1", active_profile); end
  endtask

  task automatic test_timeout;
    int n = 0;
    pll_locked = 0;
    pulse_req(0);
    wait_writes(wcnt + 9, "timeout");
    tick(399);
    total++;
    if (error !== 0 || busy !== 1) begin bad++; $display("FAIL timeout_early got=err%b busy%b exp=err0 busy1", error, busy); end
    tick();
    total++;
    if (error !== 1) begin bad++; $display("FAIL timeout_error got=%b exp=1", error); end
    total++;
    if (busy !== 0 || pll_hold !== 1 || active_profile !== 1) begin
      bad++; $display("FAIL timeout_state got=busy%b hold%b act%b exp=busy0 hold1 act1", busy, pll_hold, active_profile);
    end
    tick(5);
    pulse_req(1);
    total++;
    if (error !== 0 || busy !== 1) begin bad++; $display("FAIL timeout_clear got=err%b busy%b exp=err0 busy1", error, busy); end
    while (busy === 1 && n < 600) begin tick(); n++; end
    total++;
    if (error !== 1 || busy !== 0) begin bad++; $display("FAIL timeout_again got=err%b busy%b exp=err1 busy0", error, busy); end
  endtask

  task automatic test_lock_toggle;
    int b = 0;
    pulse_req(0);
    wait_writes(wcnt + 9, "toggle");
    repeat (3) begin
      pll_locked = 1;
      repeat (10) begin tick(); if (done !== 0) b++; end
      pll_locked = 0;
      repeat (5) begin tick(); if (done !== 0) b++; end
    end
    pll_locked = 1;
    repeat (17) begin tick(); if (done !== 0) b++; end
    total++;
    if (b != 0) begin bad++; $display("FAIL toggle_early_done got=%0d cycles exp=0", b); end
    tick();
    total++;
    if (done !== 1) begin bad++; $display("FAIL toggle_done got=%b exp=1", done); end
    total++;
    if (active_profile !== 0 || error !== 0) begin bad++; $display("FAIL toggle_final got=act%b err%b exp=00", active_profile, error); end
  endtask

  task automatic test_reset_midseq;
    int base = wcnt, b = 0, n = 0;
    pll_locked = 0;
    pulse_req(1);
    tick(3);
    pulse_req(0);
    wait_writes(base + 5, "midseq");
    for (int i = 0; i < 5; i++) if (log_a[8'(base + i)] !== exp_a[i] || log_d[8'(base + i)] !== pal_d[i]) b++;
    total++;
    if (b != 0) begin bad++; $display("FAIL midseq_extra_req got=%0d wrong entries exp=0", b); end
    while (mgmt_write !== 1 && n < 10) begin tick(); n++; end
    reset_n = 0;
    #1;
    total++;
    if ({busy, done, error, active_profile, pll_hold, mgmt_write} !== 6'b000010 || mgmt_address !== 0 || mgmt_writedata !== 0) begin
      bad++; $display("FAIL midseq_async_reset got=%b %h/%h exp=000010 00/00000000",
                      {busy, done, error, active_profile, pll_hold, mgmt_write}, mgmt_address, mgmt_writedata);
    end
    tick(2);
    reset_n = 1;
    tick(2);
    base = wcnt;
    pulse_req(0);
    wait_writes(base + 9, "fresh");
    pll_locked = 1;
    wait_done("fresh");
    b = 0;
    for (int i = 0; i < 9; i++) if (log_a[8'(base + i)] !== exp_a[i] || log_d[8'(base + i)] !== ntsc_d[i]) b++;
    total++;
    if (b != 0) begin bad++; $display("FAIL fresh_table got=%0d wrong entries exp=0", b); end
    tick();
    total++;
    if (pll_hold !== 0 || busy !== 0 || active_profile !== 0) begin
      bad++; $display("FAIL fresh_final got=hold%b busy%b act%b exp=000", pll_hold, busy, active_profile);
    end
  endtask

  initial begin
    test_reset;
    test_powerup;
    test_ntsc;
    test_pal_stall;
    test_timeout;
    test_lock_toggle;
    test_reset_midseq;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
